// File: rtl/excom_filter.sv
// Debounce filter for the EXCOM pulse input: a synchronizer, a free-running sample tick
// and a qualify FSM that only passes level changes held for THRESH ticks; small register bus.
module excom_filter #(
    parameter logic [7:0]  EXCOM_FILTER_ADDRESS = 8'h00,
    parameter int unsigned TICK_DIV             = 16,
    parameter logic [7:0]  DEFAULT_THRESH       = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic       excom_in,
    output logic       excom_out,
    output logic       excom_rise
);

    localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [7:0]    ADDR_THRESH = EXCOM_FILTER_ADDRESS;
    localparam logic [7:0]    ADDR_STATUS = EXCOM_FILTER_ADDRESS + 8'd1;
    localparam logic [7:0]    ADDR_GCNT   = EXCOM_FILTER_ADDRESS + 8'd2;

    typedef enum logic {
        STABLE,
        QUALIFY
    } state_t;

    state_t        state;
    logic          sync0;
    logic          sync1;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    qual_cnt;
    logic [8:0]    qual_next;
    logic [7:0]    thresh;
    logic [7:0]    glitch_cnt;
    logic          sticky;
    logic          glitch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= excom_in;
            sync1 <= sync0;
        end
    end

    // The prescaler is never restarted by the FSM, so the first tick of a qualification may be partial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick      = (presc == PRESC_LAST);
    assign glitch    = (state == QUALIFY) && (sync1 == excom_out);
    assign qual_next = {1'b0, qual_cnt} + 9'd1;

    // The >= compare lets a THRESH lowered mid-qualification release on the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= STABLE;
            qual_cnt   <= 8'd0;
            excom_out  <= 1'b0;
            excom_rise <= 1'b0;
        end else begin
            excom_rise <= 1'b0;
            case (state)
                STABLE: begin
                    if (sync1 != excom_out) begin
                        if (thresh == 8'd0) begin
                            excom_out  <= sync1;
                            excom_rise <= sync1;
                        end else begin
                            state    <= QUALIFY;
                            qual_cnt <= 8'd0;
                        end
                    end
                end
                QUALIFY: begin
                    if (sync1 == excom_out) begin
                        state <= STABLE;
                    end else if (tick) begin
                        qual_cnt <= qual_next[7:0];
                        if (qual_next >= {1'b0, thresh}) begin
                            excom_out  <= sync1;
                            excom_rise <= sync1;
                            state      <= STABLE;
                        end
                    end
                end
                default: state <= STABLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh     <= DEFAULT_THRESH;
            glitch_cnt <= 8'd0;
            sticky     <= 1'b0;
            dout       <= 8'd0;
        end else begin
            if (w_en && (address == ADDR_THRESH)) begin
                thresh <= din;
            end

            if (w_en && (address == ADDR_GCNT)) begin
                glitch_cnt <= glitch ? 8'd1 : 8'd0;
            end else if (glitch && (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end

            // A glitch in the same cycle as a STATUS read must not be lost.
            if (glitch) begin
                sticky <= 1'b1;
            end else if (r_en && (address == ADDR_STATUS)) begin
                sticky <= 1'b0;
            end

            dout <= 8'd0;
            if (r_en) begin
                case (address)
                    ADDR_THRESH: dout <= thresh;
                    ADDR_STATUS: dout <= {6'd0, sticky, excom_out};
                    ADDR_GCNT:   dout <= glitch_cnt;
                    default:     dout <= 8'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_excom_filter.sv
// Self-checking bench for excom_filter: a table of bus vectors followed by
// directed multi-cycle sequences for qualification, glitches, bypass and reset.
module tb_excom_filter;

    localparam logic [7:0] BASE = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic       excom_in;
    logic       excom_out;
    logic       excom_rise;

    int total_checks  = 0;
    int passed_checks = 0;

    always #5 clk = ~clk;

    excom_filter #(
        .EXCOM_FILTER_ADDRESS(BASE),
        .TICK_DIV(16),
        .DEFAULT_THRESH(8'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .address(address),
        .w_en(w_en),
        .r_en(r_en),
        .dout(dout),
        .excom_in(excom_in),
        .excom_out(excom_out),
        .excom_rise(excom_rise)
    );

    typedef struct {
        string      name;
        logic       w_en;
        logic       r_en;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_dout;
    } bus_vec_t;

    bus_vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", name, actual, expected);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {7'd0, actual}, {7'd0, expected});
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        total_checks++;
        if (actual >= lo && actual <= hi) passed_checks++;
        else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    endtask

    task automatic applyStimulus(input bus_vec_t v);
        @(negedge clk);
        w_en    = v.w_en;
        r_en    = v.r_en;
        address = v.addr;
        din     = v.data;
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        checkOutput(v.name, dout, v.exp_dout);
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        din     = d;
        w_en    = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic busRead(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        r_en    = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        d    = dout;
    endtask

    task automatic waitOut(input logic level, input int bound, output int edges);
        edges = 0;
        while (excom_out !== level && edges < bound) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic glitchPulse();
        @(negedge clk);
        excom_in = 1'b1;
        repeat (4) @(negedge clk);
        excom_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rd;
        int          edges;
        logic        rose;
        logic [23:0] pattern;
        logic [3:0]  hist;

        rst = 1'b1;
        excom_in = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        address = 8'h00;
        din = 8'h00;
        repeat (3) @(negedge clk);
        checkBit("reset_excom_out", excom_out, 1'b0);
        checkBit("reset_excom_rise", excom_rise, 1'b0);
        checkOutput("reset_dout", dout, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0]  = '{"wr_thresh_05",      1'b1, 1'b0, BASE,         8'h05, 8'h00};
        vecs[1]  = '{"rd_thresh_05",      1'b0, 1'b1, BASE,         8'h00, 8'h05};
        vecs[2]  = '{"rd_thresh_no_ren",  1'b0, 1'b0, BASE,         8'h00, 8'h00};
        vecs[3]  = '{"rd_thresh_again",   1'b0, 1'b1, BASE,         8'h00, 8'h05};
        vecs[4]  = '{"rd_unmapped_b3",    1'b0, 1'b1, BASE + 8'd3,  8'h00, 8'h00};
        vecs[5]  = '{"wr_status_ignored", 1'b1, 1'b0, BASE + 8'd1,  8'hFF, 8'h00};
        vecs[6]  = '{"rd_status_idle",    1'b0, 1'b1, BASE + 8'd1,  8'h00, 8'h00};
        vecs[7]  = '{"wr_unmapped_b3",    1'b1, 1'b0, BASE + 8'd3,  8'h33, 8'h00};
        vecs[8]  = '{"rd_thresh_kept",    1'b0, 1'b1, BASE,         8'h00, 8'h05};
        vecs[9]  = '{"wr_thresh_08",      1'b1, 1'b0, BASE,         8'h08, 8'h00};
        vecs[10] = '{"rd_thresh_08",      1'b0, 1'b1, BASE,         8'h00, 8'h08};
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
        busRead(BASE + 8'd2, rd);
        checkOutput("rd_glitch_cnt_idle", rd, 8'h00);

        // Clean rising edge with THRESH = 8.
        @(negedge clk);
        excom_in = 1'b1;
        waitOut(1'b1, 300, edges);
        checkBit("clean_out_high", excom_out, 1'b1);
        checkRange("clean_latency", edges - 1, 114, 130);
        checkBit("clean_rise_pulse", excom_rise, 1'b1);
        @(negedge clk);
        checkBit("clean_rise_width", excom_rise, 1'b0);
        repeat (70) @(negedge clk);
        busRead(BASE + 8'd2, rd);
        checkOutput("clean_glitch_cnt", rd, 8'h00);
        checkBit("clean_out_held", excom_out, 1'b1);

        // Falling transition qualifies without a rise strobe.
        @(negedge clk);
        excom_in = 1'b0;
        waitOut(1'b0, 300, edges);
        checkBit("fall_out_low", excom_out, 1'b0);
        checkBit("fall_no_rise", excom_rise, 1'b0);
        repeat (10) @(negedge clk);

        // 50-cycle pulse is a glitch.
        rose = 1'b0;
        @(negedge clk);
        excom_in = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (excom_out) rose = 1'b1;
        end
        excom_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (excom_out) rose = 1'b1;
        end
        checkBit("glitch_out_stays_low", rose, 1'b0);
        busRead(BASE + 8'd2, rd);
        checkOutput("glitch_cnt_one", rd, 8'h01);
        busRead(BASE + 8'd1, rd);
        checkOutput("status_sticky", rd, 8'h02);
        busRead(BASE + 8'd1, rd);
        checkOutput("status_cleared", rd, 8'h00);

        // Saturation and clear of the glitch counter.
        for (int i = 0; i < 300; i++) glitchPulse();
        repeat (4) @(negedge clk);
        busRead(BASE + 8'd2, rd);
        checkOutput("glitch_cnt_sat", rd, 8'hFF);
        busWrite(BASE + 8'd2, 8'h00);
        busRead(BASE + 8'd2, rd);
        checkOutput("glitch_cnt_clr", rd, 8'h00);
        glitchPulse();
        glitchPulse();
        repeat (4) @(negedge clk);
        busRead(BASE + 8'd2, rd);
        checkOutput("glitch_cnt_two", rd, 8'h02);

        // Write to GLITCH_CNT on the exact cycle the glitch is recorded.
        @(negedge clk);
        excom_in = 1'b1;
        repeat (4) @(negedge clk);
        excom_in = 1'b0;
        repeat (2) @(negedge clk);
        address = BASE + 8'd2;
        din = 8'h5A;
        w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        repeat (4) @(negedge clk);
        busRead(BASE + 8'd2, rd);
        checkOutput("wr_and_glitch", rd, 8'h01);

        // Bypass: excom_out follows excom_in three edges later.
        busWrite(BASE, 8'h00);
        repeat (2) @(negedge clk);
        pattern = 24'b0000_0000_1000_1101_0011_1111;
        hist = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checkBit("bypass_out", excom_out, hist[2]);
            checkBit("bypass_rise", excom_rise, hist[2] & ~hist[3]);
            excom_in = pattern[i];
            hist = {hist[2:0], pattern[i]};
        end
        repeat (5) @(negedge clk);

        // Lowering THRESH mid-qualification releases on the next tick.
        busWrite(BASE, 8'h08);
        @(negedge clk);
        excom_in = 1'b1;
        repeat (60) @(negedge clk);
        checkBit("thr_pre_write_low", excom_out, 1'b0);
        busWrite(BASE, 8'h01);
        waitOut(1'b1, 20, edges);
        checkBit("thr_lowered_out", excom_out, 1'b1);
        checkRange("thr_lowered_latency", edges, 1, 16);

        // Asynchronous reset in the middle of a falling qualification.
        busWrite(BASE, 8'h0A);
        @(negedge clk);
        excom_in = 1'b0;
        repeat (80) @(negedge clk);
        busRead(BASE, rd);
        checkOutput("pre_reset_read", rd, 8'h0A);
        checkBit("pre_reset_out_high", excom_out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkBit("rst_out_async", excom_out, 1'b0);
        checkBit("rst_rise_async", excom_rise, 1'b0);
        checkOutput("rst_dout_async", dout, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        busRead(BASE, rd);
        checkOutput("thresh_after_reset", rd, 8'h08);
        busRead(BASE + 8'd2, rd);
        checkOutput("glitch_cnt_after_reset", rd, 8'h00);
        busRead(BASE + 8'd1, rd);
        checkOutput("status_after_reset", rd, 8'h00);
        repeat (20) @(negedge clk);
        checkBit("out_after_reset", excom_out, 1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/excom_filter.md
EXCOM_FILTER -- requirements
Module: excom_filter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other ports are listed below.
REQ-002 Parameter EXCOM_FILTER_ADDRESS SHALL default to 8'h00 and SHALL be the register base address (base).
REQ-003 Parameter TICK_DIV SHALL default to 16 and SHALL set the number of clk cycles per sample tick (1 us at 16 MHz).
REQ-004 Parameter DEFAULT_THRESH SHALL default to 8 and SHALL set the reset value of the threshold register.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 din  input  8  bus write data.
REQ-008 address  input  8  bus address.
REQ-009 w_en  input  1  bus write strobe, one cycle per write.
REQ-010 r_en  input  1  bus read strobe, one cycle per read.
REQ-011 dout  output  8  registered bus read data.
REQ-012 excom_in  input  1  raw, asynchronous external pulse input.
REQ-013 excom_out  output  1  debounced level for the downstream edge counter.
REQ-014 excom_rise  output  1  one-cycle strobe on each qualified 0->1 transition of excom_out.

Function
REQ-015 excom_in SHALL pass through a 2-flop synchronizer (sync1); sync1 lags excom_in by 2 cycles.
REQ-016 A prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle when it wraps from TICK_DIV-1 to 0.
REQ-017 The prescaler SHALL run freely; state changes SHALL NOT reset it.
REQ-018 Register map: base+0 THRESH (R/W, 8 bit); base+1 STATUS (R: bit0 excom_out, bit1 sticky glitch flag, bits7:2 = 0); base+2 GLITCH_CNT (R; any write clears it).
REQ-019 FSM states SHALL be STABLE and QUALIFY; reset state STABLE.
REQ-020 In STABLE with sync1 != excom_out: if THRESH = 0, the FSM SHALL stay in STABLE and excom_out SHALL take sync1 on that clock edge; otherwise the FSM SHALL enter QUALIFY and clear qual_cnt.
REQ-021 In QUALIFY, if sync1 == excom_out on any cycle, the event SHALL count as a glitch. The FSM SHALL return to STABLE, increment GLITCH_CNT (saturating at 255) and set the sticky flag; excom_out SHALL stay unchanged.
REQ-022 In QUALIFY, on each tick cycle with sync1 != excom_out, qual_cnt SHALL increment. When the incremented value equals THRESH, excom_out SHALL take sync1 on that edge and the FSM SHALL return to STABLE.
REQ-023 Qualification latency SHALL be THRESH ticks after entering QUALIFY; the first tick may be partial, so latency is (THRESH-1)*TICK_DIV+1 to THRESH*TICK_DIV cycles.
REQ-024 excom_rise SHALL be 1 for exactly the cycle after excom_out goes 0->1; falling transitions SHALL NOT pulse it.
REQ-025 A THRESH write during QUALIFY SHALL take effect immediately. If qual_cnt is already >= the new THRESH, the next tick SHALL qualify the transition.
REQ-026 Reads: on each cycle, if r_en is 1 and address is base+0..2, dout SHALL take that register's value on the next edge; otherwise dout SHALL be 0 (1-cycle read latency).
REQ-027 A STATUS read SHALL clear the sticky flag after returning it. If a glitch occurs in the same cycle, the set SHALL win.
REQ-028 If a GLITCH_CNT write and a glitch occur in the same cycle, GLITCH_CNT SHALL become 1.
REQ-029 Writes to any other address SHALL be ignored.

Reset
REQ-030 While rst = 1, the following SHALL hold: sync1 = 0, prescaler = 0, FSM = STABLE, qual_cnt = 0, excom_out = 0, excom_rise = 0, dout = 0, THRESH = DEFAULT_THRESH, GLITCH_CNT = 0, sticky flag = 0.
REQ-031 Asserting rst in mid-qualification SHALL abandon the pending transition and SHALL NOT count a glitch.

Verification
REQ-032 Clean edge: THRESH = 8; hold excom_in at 1 for 200 cycles -> excom_out rises 114..130 cycles after the input edge; excom_rise = 1 for one cycle; GLITCH_CNT = 0.
REQ-033 Glitch: THRESH = 8; 1 for 50 cycles, then 0 -> excom_out stays 0; GLITCH_CNT = 1; a STATUS read returns 8'h02, then the next read returns 8'h00.
REQ-034 Bypass: write 0 to base+0, then toggle excom_in -> excom_out follows excom_in with exactly 3 cycles of delay.
REQ-035 Saturation/clear: apply 300 glitches -> GLITCH_CNT reads 255; write base+2 -> reads 0; write and glitch in the same cycle -> reads 1.
REQ-036 Reset: assert rst at qual_cnt = 5 -> all outputs 0 immediately; THRESH reads 8 after release.
REQ-037 Bus: read base+3 -> dout = 0; read base+0 with r_en = 0 -> dout = 0.
